// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one byte to the device over open-drain clock/data enables.
// Latency: INHIBIT_CYCLES + RTS_CYCLES + 11 device clocks + wait for idle lines, per byte.
// Backpressure: tx_ready low from acceptance until the cycle after done/error; tx_valid is ignored meanwhile.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2400,
  parameter int RTS_CYCLES     = 48,
  parameter int TIMEOUT_CYCLES = 360000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam int CNT_MAX_A = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_BITS,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [9:0]       shift;
  logic [3:0]       idx;
  logic             ack_ok;

  logic clk_meta, sync_clk, sync_clk_prev;
  logic dat_meta, sync_dat;
  logic fall_edge;

  // Two-flop synchronizers for both pins plus one delayed copy of clock for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta      <= 1'b1;
      sync_clk      <= 1'b1;
      sync_clk_prev <= 1'b1;
      dat_meta      <= 1'b1;
      sync_dat      <= 1'b1;
    end else begin
      clk_meta      <= ps2_clk_i;
      sync_clk      <= clk_meta;
      sync_clk_prev <= sync_clk;
      dat_meta      <= ps2_dat_i;
      sync_dat      <= dat_meta;
    end
  end

  assign fall_edge = sync_clk_prev & ~sync_clk;

  // Protocol FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shift      <= '0;
      idx        <= '0;
      ack_ok     <= 1'b0;
      tx_ready   <= 1'b1;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      busy       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          // tx_ready is the registered flag, so the cycle right after a pulse cannot accept.
          if (tx_valid && tx_ready) begin
            shift      <= {1'b1, ~^tx_data, tx_data};
            cnt        <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          // Device edges are meaningless here: the host itself holds the clock low.
          if (cnt == INH_LAST) begin
            cnt        <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= S_RTS;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_RTS: begin
          if (cnt == RTS_LAST) begin
            cnt        <= '0;
            idx        <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= S_BITS;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_BITS, S_ACK, S_WAIT_IDLE: begin
          if (fall_edge) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end

          if (!fall_edge && cnt == TO_LAST) begin
            // Device went silent: free the bus and report failure.
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_error   <= 1'b1;
            cnt        <= '0;
            state      <= S_IDLE;
          end else begin
            case (state)
              S_BITS: begin
                if (fall_edge) begin
                  ps2_dat_oe <= ~shift[idx];
                  idx        <= idx + 4'd1;
                  if (idx == 4'd9) begin
                    state <= S_ACK;
                  end
                end
              end
              S_ACK: begin
                if (fall_edge) begin
                  ack_ok <= ~sync_dat;
                  state  <= S_WAIT_IDLE;
                end
              end
              default: begin
                if (sync_clk && sync_dat) begin
                  tx_done  <= ack_ok;
                  tx_error <= ~ack_ok;
                  cnt      <= '0;
                  state    <= S_IDLE;
                end
              end
            endcase
          end
        end

        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule
